mac_stream_dot: RTL

Parametrised streaming multiply-accumulate unit; next generation of the 4-bit MAC. Accepts a stream of (w, x) operand pairs over a valid/ready handshake, accumulates exactly LEN products into a single dot-product result, and presents that result on an output valid/ready handshake. It sits between the operand-fetch logic and the result collector of the matrix-multiplication array, one instance per output element.

---
 rtl/mac_pkg.sv | 28 ++
 rtl/mac_mult_stage.sv | 41 ++++
 rtl/mac_stream_dot.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the streaming dot-product MAC (mac_stream_dot):
//   - state_t       : controller states (accumulate, drain, hold result)
//   - cnt_width()   : accept-counter width for a given vector length
//   - params_legal(): parameter legality check used by the top level
// ---------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,   // accepting operand pairs
        ST_DRAIN = 2'd1,   // last product still in flight to the accumulator
        ST_HOLD  = 2'd2    // result presented, waiting for the consumer
    } state_t;

    // Counter must hold 0..len-1; a 1-bit counter is kept for len == 1 so
    // the vector never collapses to zero width.
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    function automatic bit params_legal(input int dw, input int len, input int acc_w);
        return (dw >= 2) && (dw <= 16) &&
               (len >= 1) && (len <= 256) &&
               (acc_w >= 2 * dw);
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// ---------------------------------------------------------------------------
// mac_mult_stage
// Registered unsigned DW x DW multiplier with a valid bit.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   clear       : synchronous flush of the product register and valid bit
//   load        : an operand pair is accepted this cycle
//   a, b        : unsigned operands (DW bits)
//   p           : registered product (2*DW bits)
//   p_valid     : p holds a product accepted on the previous edge
// ---------------------------------------------------------------------------
module mac_mult_stage #(
    parameter int DW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DW-1:0]     a,
    input  logic [DW-1:0]     b,
    output logic [2*DW-1:0]   p,
    output logic              p_valid
);

    localparam int PW = 2 * DW;

    // NOTE: sequential state is always written with <= so every register
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            p       <= '0;
            p_valid <= 1'b0;
        end else begin
            p_valid <= load;
            if (load) begin
                p <= PW'(a) * PW'(b);
            end
        end
    end

endmodule

// File: rtl/mac_stream_dot.sv
// ---------------------------------------------------------------------------
// mac_stream_dot
// Streaming multiply-accumulate: accepts LEN (w, x) pairs over a valid/ready
// handshake, sums their unsigned products into one ACC_W-bit result and
// presents it on an output valid/ready handshake.
//
// Optional feature macro: MAC_SATURATE_EN
//   defined   : on overflow the accumulator clamps to all-ones and stays there
//               for the rest of the result
//   undefined : the accumulator wraps modulo 2^ACC_W
//   ovf is set on the first carry out of ACC_W in either build.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : synchronous abort of partial sum and pending result
//   in_valid   : operand pair valid          in_ready : pair accepted this cycle
//   w, x       : unsigned operands (DW bits)
//   out_valid  : result valid                out_ready: consumer takes result
//   out_data   : dot-product (ACC_W bits)    ovf      : result overflowed
// All outputs are decoded from registers only.
// ---------------------------------------------------------------------------
module mac_stream_dot
    import mac_pkg::*;
#(
    parameter int DW    = 4,
    parameter int LEN   = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    w,
    input  logic [DW-1:0]    x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             ovf
);

    localparam int            PW         = 2 * DW;
    localparam int            CW         = cnt_width(LEN);
    localparam logic [CW-1:0] CNT_LAST   = CW'(LEN - 1);
    localparam bit            PARAMS_OK  = params_legal(DW, LEN, ACC_W);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("mac_stream_dot: illegal DW/LEN/ACC_W combination");
        end
    endgenerate

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [ACC_W-1:0]  acc;
    logic              ovf_r;
    logic              accept;
    logic              last_accept;
    logic              take;
    logic [PW-1:0]     prod;
    logic              prod_valid;
    logic [ACC_W:0]    sum;
    logic              carry;

    assign in_ready    = (state == ST_ACC);
    assign out_valid   = (state == ST_HOLD);
    assign out_data    = acc;
    assign ovf         = ovf_r;

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (cnt == CNT_LAST);
    assign take        = out_valid && out_ready;

    mac_mult_stage #(
        .DW (DW)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .load    (accept),
        .a       (w),
        .b       (x),
        .p       (prod),
        .p_valid (prod_valid)
    );

    // One extra bit on the adder exposes the carry out of ACC_W.
    assign sum   = {1'b0, acc} + {{(ACC_W + 1 - PW){1'b0}}, prod};
    assign carry = sum[ACC_W];

    // NOTE: next_state gets its default before the case so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_ACC:   if (last_accept) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_HOLD;
            ST_HOLD:  if (out_ready) state_next = ST_ACC;
            default:  state_next = ST_ACC;
        endcase
    end

    // NOTE: reset is synchronous and folded together with clear; rst_n is
    // listed first so it wins regardless of clear.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= last_accept ? '0 : cnt + 1'b1;
        end
    end

    // The final product lands during DRAIN, so a product and the output
    // handshake never arrive on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            acc   <= '0;
            ovf_r <= 1'b0;
        end else if (take) begin
            acc   <= '0;
            ovf_r <= 1'b0;
        end else if (prod_valid) begin
            ovf_r <= ovf_r | carry;
`ifdef MAC_SATURATE_EN
            // Once clamped, stay at full scale even if later adds fit.
            acc   <= (carry || ovf_r) ? '1 : sum[ACC_W-1:0];
`else
            acc   <= sum[ACC_W-1:0];
`endif
        end
    end

endmodule
